// File: rtl/sram_emu.sv
// sram_emu: pin-level device side of a 256Kx16 asynchronous SRAM, backed by an internal word array.
// Define SRAM_EMU_CHECK_EN to build the access counters and the sticky protocol error flags.
module sram_emu #(
  parameter int    AW        = 14,
  parameter string INIT_FILE = "",
  parameter int    CW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  inout  wire  [15:0]   sram_dq,
  input  logic [17:0]   sram_addr,
  input  logic          sram_ub_n,
  input  logic          sram_lb_n,
  input  logic          sram_we_n,
  input  logic          sram_ce_n,
  input  logic          sram_oe_n,
  output logic [1:0]    acc_state,
  output logic [CW-1:0] rd_cnt,
  output logic [CW-1:0] wr_cnt,
  output logic [CW-1:0] turn_cnt,
  output logic          err_contention,
  output logic          err_range,
  output logic          err_nomask
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } acc_t;

  logic [15:0]   mem [DEPTH];
  logic          wr_cyc;
  logic          rd_cyc;
  logic          in_range;
  logic          mem_we;
  logic [AW-1:0] word_addr;
  logic [15:0]   rd_data;
  acc_t          state_q;
  acc_t          state_d;

  // A low write enable wins over output enable, so contention still writes.
  assign wr_cyc    = !sram_ce_n && !sram_we_n;
  assign rd_cyc    = !sram_ce_n && sram_we_n && !sram_oe_n;
  assign word_addr = sram_addr[AW-1:0];

  generate
    if (AW < 18) begin : g_range
      assign in_range = (sram_addr[17:AW] == '0);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  // Reset gates the write strobe so a write on a reset edge is never committed.
  assign mem_we = wr_cyc && in_range && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (!sram_ub_n) mem[word_addr][15:8] <= sram_dq[15:8];
      if (!sram_lb_n) mem[word_addr][7:0]  <= sram_dq[7:0];
    end
  end

  assign rd_data       = in_range ? mem[word_addr] : 16'h0000;
  assign sram_dq[15:8] = (rd_cyc && !sram_ub_n && !rst) ? rd_data[15:8] : 8'hzz;
  assign sram_dq[7:0]  = (rd_cyc && !sram_lb_n && !rst) ? rd_data[7:0]  : 8'hzz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (wr_cyc) begin
      state_d = ST_WRITE;
    end else if (rd_cyc) begin
      state_d = ST_READ;
    end
  end

  assign acc_state = state_q;

`ifdef SRAM_EMU_CHECK_EN
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] rd_cnt_q;
  logic [CW-1:0] wr_cnt_q;
  logic [CW-1:0] turn_cnt_q;
  logic          contention_q;
  logic          range_q;
  logic          nomask_q;
  logic          turn;
  logic          access;

  assign access = rd_cyc || wr_cyc;
  assign turn   = ((state_q == ST_READ)  && (state_d == ST_WRITE)) ||
                  ((state_q == ST_WRITE) && (state_d == ST_READ));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      turn_cnt_q   <= '0;
      contention_q <= 1'b0;
      range_q      <= 1'b0;
      nomask_q     <= 1'b0;
    end else begin
      if (rd_cyc) rd_cnt_q   <= rd_cnt_q + ONE;
      if (wr_cyc) wr_cnt_q   <= wr_cnt_q + ONE;
      if (turn)   turn_cnt_q <= turn_cnt_q + ONE;
      if (!sram_ce_n && !sram_we_n && !sram_oe_n) contention_q <= 1'b1;
      if (access && !in_range)                    range_q      <= 1'b1;
      if (access && sram_ub_n && sram_lb_n)       nomask_q     <= 1'b1;
    end
  end

  assign rd_cnt         = rd_cnt_q;
  assign wr_cnt         = wr_cnt_q;
  assign turn_cnt       = turn_cnt_q;
  assign err_contention = contention_q;
  assign err_range      = range_q;
  assign err_nomask     = nomask_q;
`else
  assign rd_cnt         = '0;
  assign wr_cnt         = '0;
  assign turn_cnt       = '0;
  assign err_contention = 1'b0;
  assign err_range      = 1'b0;
  assign err_nomask     = 1'b0;
`endif

endmodule

// File: tb/tb_sram_emu.sv
// Bench for sram_emu: directed bus scenarios plus random cycles against a word-array reference model.
module tb_sram_emu;
  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = 32;
`ifdef SRAM_EMU_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  wire  [15:0]   sram_dq;
  logic [15:0]   tb_dq;
  logic          tb_drive;
  logic [17:0]   addr;
  logic          ub_n, lb_n, we_n, ce_n, oe_n;
  logic [1:0]    acc_state;
  logic [CW-1:0] rd_cnt, wr_cnt, turn_cnt;
  logic          err_contention, err_range, err_nomask;

  assign sram_dq = tb_drive ? tb_dq : 16'hzzzz;
  always #5 clk = ~clk;

  sram_emu #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .sram_dq(sram_dq), .sram_addr(addr),
    .sram_ub_n(ub_n), .sram_lb_n(lb_n), .sram_we_n(we_n), .sram_ce_n(ce_n), .sram_oe_n(oe_n),
    .acc_state(acc_state), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .turn_cnt(turn_cnt),
    .err_contention(err_contention), .err_range(err_range), .err_nomask(err_nomask)
  );

  // Reference model: word contents, which bytes hold known data, and the bus-level bookkeeping.
  logic [15:0] m_mem   [DEPTH];
  logic [1:0]  m_known [DEPTH];
  int unsigned m_rd, m_wr, m_turn;
  logic [1:0]  m_state;
  logic        m_econ, m_erng, m_emask;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic undriven(input logic [7:0] b);
    return (b === 8'hzz) || (b === 8'h00);
  endfunction

  task automatic check_byte(input string tag, input logic en, input logic inr,
                            input logic known, input logic [7:0] mval, input logic [7:0] obs);
    if (!en) begin
      if (!tb_drive) check({tag, "_z"}, 32'(undriven(obs)), 32'd1);
    end else if (!inr) begin
      check(tag, 32'(obs), 32'd0);
    end else if (known) begin
      check(tag, 32'(obs), 32'(mval));
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, "/acc_state"}, 32'(acc_state), 32'(m_state));
    check({tag, "/rd_cnt"},    32'(rd_cnt),    CHK_EN ? m_rd   : 32'd0);
    check({tag, "/wr_cnt"},    32'(wr_cnt),    CHK_EN ? m_wr   : 32'd0);
    check({tag, "/turn_cnt"},  32'(turn_cnt),  CHK_EN ? m_turn : 32'd0);
    check({tag, "/err_cont"},  32'(err_contention), CHK_EN ? 32'(m_econ)  : 32'd0);
    check({tag, "/err_range"}, 32'(err_range),      CHK_EN ? 32'(m_erng)  : 32'd0);
    check({tag, "/err_nomask"},32'(err_nomask),     CHK_EN ? 32'(m_emask) : 32'd0);
  endtask

  task automatic set_pins(input logic ce, we, oe, ub, lb, input logic [17:0] a, input logic [15:0] d);
    ce_n = ce; we_n = we; oe_n = oe; ub_n = ub; lb_n = lb; addr = a; tb_dq = d;
    tb_drive = !ce && !we;
  endtask

  // One bus cycle: pins change on the falling edge, data is sampled before the rising edge.
  task automatic bus_cycle(input string tag, input logic ce, we, oe, ub, lb,
                           input logic [17:0] a, input logic [15:0] d);
    logic       wr, rd, inr;
    logic [1:0] ns;
    logic [15:0] dq_seen;
    int         w;
    @(negedge clk);
    set_pins(ce, we, oe, ub, lb, a, d);
    wr  = !ce && !we;
    rd  = !ce && we && !oe;
    inr = (32'(a) < DEPTH);
    w   = int'(a[AW-1:0]);
    #1;
    dq_seen = sram_dq;
    if (wr) begin
      check({tag, "/wr_bus"}, 32'(sram_dq), 32'(d));
    end else begin
      check_byte({tag, "/hi"}, rd && !ub, inr, m_known[w][1], m_mem[w][15:8], sram_dq[15:8]);
      check_byte({tag, "/lo"}, rd && !lb, inr, m_known[w][0], m_mem[w][7:0],  sram_dq[7:0]);
    end
    @(posedge clk);
    #1;
    if (wr && inr) begin
      if (!ub) begin m_mem[w][15:8] = d[15:8]; m_known[w][1] = 1'b1; end
      if (!lb) begin m_mem[w][7:0]  = d[7:0];  m_known[w][0] = 1'b1; end
    end
    ns = wr ? 2'd2 : (rd ? 2'd1 : 2'd0);
    if ((m_state == 2'd1 && ns == 2'd2) || (m_state == 2'd2 && ns == 2'd1)) m_turn++;
    m_state = ns;
    if (rd) m_rd++;
    if (wr) m_wr++;
    if (!ce && !we && !oe)      m_econ  = 1'b1;
    if ((rd || wr) && !inr)     m_erng  = 1'b1;
    if ((rd || wr) && ub && lb) m_emask = 1'b1;
    $display("%0t %s ce=%b we=%b oe=%b ub=%b lb=%b a=%h d=%h dq=%h st=%0d",
             $time, tag, ce, we, oe, ub, lb, a, d, dq_seen, acc_state);
    check_regs(tag);
  endtask

  // Reset asserted mid-cycle with the given pins; outputs must clear before any clock edge.
  task automatic do_reset(input string tag, input logic ce, we, oe, ub, lb,
                          input logic [17:0] a, input logic [15:0] d);
    @(negedge clk);
    set_pins(ce, we, oe, ub, lb, a, d);
    rst = 1'b1;
    m_state = 2'd0; m_rd = 0; m_wr = 0; m_turn = 0;
    m_econ = 1'b0; m_erng = 1'b0; m_emask = 1'b0;
    #1;
    check_regs({tag, "/async"});
    if (!tb_drive) begin
      check({tag, "/hi_z"}, 32'(undriven(sram_dq[15:8])), 32'd1);
      check({tag, "/lo_z"}, 32'(undriven(sram_dq[7:0])),  32'd1);
    end
    @(posedge clk);
    #1;
    check_regs({tag, "/hold"});
    $display("%0t %s reset ce=%b we=%b oe=%b a=%h d=%h", $time, tag, ce, we, oe, a, d);
    @(negedge clk);
    rst = 1'b0;
    set_pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    set_pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0);
    for (int i = 0; i < DEPTH; i++) begin
      m_known[i] = 2'b00;
      m_mem[i]   = 16'h0000;
    end

    do_reset("init", 1, 1, 1, 1, 1, 18'h0, 16'h0);

    // Basic write then read, with the counters at one each.
    bus_cycle("s1_wr", 0, 0, 1, 0, 0, 18'h00010, 16'hA5C3);
    bus_cycle("s1_rd", 0, 1, 0, 0, 0, 18'h00010, 16'h0000);
    check("s1/wr_cnt_one", 32'(wr_cnt), CHK_EN ? 32'd1 : 32'd0);
    check("s1/rd_cnt_one", 32'(rd_cnt), CHK_EN ? 32'd1 : 32'd0);
    check("s1/model_word", 32'(m_mem[16'h0010]), 32'h0000_A5C3);

    // Reset with a read on the pins: state clears at once and the bus floats.
    do_reset("rst_rd", 0, 1, 0, 0, 0, 18'h00010, 16'h0000);
    // A write sitting on a reset edge must not reach memory.
    do_reset("rst_wr", 0, 0, 1, 0, 0, 18'h00010, 16'hDEAD);
    bus_cycle("rst_wr_rd", 0, 1, 0, 0, 0, 18'h00010, 16'h0000);

    // Byte-masked write and byte-masked read.
    bus_cycle("s2_wr",   0, 0, 1, 0, 0, 18'h00020, 16'h1234);
    bus_cycle("s2_wlo",  0, 0, 1, 1, 0, 18'h00020, 16'hFFFF);
    bus_cycle("s2_rd",   0, 1, 0, 0, 0, 18'h00020, 16'h0000);
    bus_cycle("s2_rdhi", 0, 1, 0, 0, 1, 18'h00020, 16'h0000);
    check("s2/model_word", 32'(m_mem[16'h0020]), 32'h0000_12FF);

    // Read/write/read with no idle cycles between them.
    do_reset("s3", 1, 1, 1, 1, 1, 18'h0, 16'h0);
    bus_cycle("s3_pre",  0, 0, 1, 0, 0, 18'h00001, 16'h0F0F);
    bus_cycle("s3_idle", 1, 1, 1, 1, 1, 18'h00000, 16'h0000);
    bus_cycle("s3_rd1",  0, 1, 0, 0, 0, 18'h00001, 16'h0000);
    bus_cycle("s3_wr2",  0, 0, 1, 0, 0, 18'h00002, 16'h00F0);
    bus_cycle("s3_rd2",  0, 1, 0, 0, 0, 18'h00002, 16'h0000);
    check("s3/turn_cnt_two", 32'(turn_cnt), CHK_EN ? 32'd2 : 32'd0);

    // Contention still writes, the flag sticks, and reset clears it.
    bus_cycle("s4_cont", 0, 0, 0, 0, 0, 18'h00030, 16'h5A5A);
    bus_cycle("s4_idle", 1, 1, 1, 1, 1, 18'h00000, 16'h0000);
    bus_cycle("s4_rd",   0, 1, 0, 0, 0, 18'h00030, 16'h0000);
    do_reset("s4_rst", 1, 1, 1, 1, 1, 18'h0, 16'h0);

    // Out-of-range write is dropped and does not alias onto word 0.
    bus_cycle("s5_w0",  0, 0, 1, 0, 0, 18'h00000, 16'h1111);
    bus_cycle("s5_oor", 0, 0, 1, 0, 0, 18'h04000, 16'hBEEF);
    bus_cycle("s5_rd0", 0, 1, 0, 0, 0, 18'h00000, 16'h0000);
    bus_cycle("s5_rdo", 0, 1, 0, 0, 0, 18'h04000, 16'h0000);
    bus_cycle("s5_rdt", 0, 1, 0, 0, 0, 18'h3FFFF, 16'h0000);

    // Mask-free write leaves memory alone.
    bus_cycle("nm_wr", 0, 0, 1, 1, 1, 18'h00010, 16'h0000);
    bus_cycle("nm_rd", 0, 1, 0, 0, 0, 18'h00010, 16'h0000);

    do_reset("rnd", 1, 1, 1, 1, 1, 18'h0, 16'h0);
    for (int i = 0; i < 400; i++) begin
      logic [17:0] ra;
      ra = ($urandom_range(0, 15) == 0) ? (18'h04000 + 18'($urandom_range(0, 3)))
                                         : 18'($urandom_range(0, 15));
      bus_cycle("rnd", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ra, 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
